// File: rtl/shift_pkg.sv
// Shared op encodings for the pipelined barrel shifter.
package shift_pkg;
  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SH_LSL = 2'b00;
  localparam shift_op_t SH_LSR = 2'b01;
  localparam shift_op_t SH_ASR = 2'b10;
  localparam shift_op_t SH_ROR = 2'b11;
endpackage

// File: rtl/shift_stage.sv
// One barrel-shifter pipeline slice: conditional 2^K shift, register slice, valid/ready.
// Carry tracking exists only under BARREL_SHIFT_PIPE_FLAGS_EN.
module shift_stage
  import shift_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int SHAMT_W = 4,
  parameter int K       = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               prev_valid,
  output logic               ready,
  input  logic [WIDTH-1:0]   prev_data,
  input  logic [SHAMT_W-1:0] prev_shamt,
  input  shift_op_t          prev_op,
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  input  logic               prev_carry,
  output logic               carry,
`endif
  input  logic               next_ready,
  output logic               valid,
  output logic [WIDTH-1:0]   data,
  output logic [SHAMT_W-1:0] shamt,
  output shift_op_t          op
);
  localparam int S = 1 << K;

  logic [WIDTH-1:0] shifted;
  logic             take;

  always_comb begin
    shifted = prev_data;
    case (prev_op)
      SH_LSL:  shifted = {prev_data[WIDTH-S-1:0], {S{1'b0}}};
      SH_LSR:  shifted = {{S{1'b0}}, prev_data[WIDTH-1:S]};
      SH_ASR:  shifted = {{S{prev_data[WIDTH-1]}}, prev_data[WIDTH-1:S]};
      default: shifted = {prev_data[S-1:0], prev_data[WIDTH-1:S]};
    endcase
  end

  assign ready = !valid || next_ready;
  assign take  = prev_valid && ready;

`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  // Last bit leaving this stage; for ROR that bit is also the new MSB.
  logic shift_carry;
  assign shift_carry = (prev_op == SH_LSL) ? prev_data[WIDTH-S] : prev_data[S-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
      carry <= 1'b0;
`endif
    end else begin
      if (ready) valid <= prev_valid;
      if (take) begin
        data  <= prev_shamt[K] ? shifted : prev_data;
        shamt <= prev_shamt;
        op    <= prev_op;
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
        carry <= prev_shamt[K] ? shift_carry : prev_carry;
`endif
      end
    end
  end
endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: SHAMT_W handshaked stages, LSL/LSR/ASR/ROR.
// Define BARREL_SHIFT_PIPE_FLAGS_EN to add out_carry/out_zero.
module barrel_shift_pipe
  import shift_pkg::*;
#(
  parameter  int WIDTH   = 16,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  shift_op_t          in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  ,
  output logic               out_carry,
  output logic               out_zero
`endif
);
  // Index 0 is the input port; index k+1 is the register of stage k.
  logic      [SHAMT_W:0]              vld_pipe;
  logic      [SHAMT_W:0]              rdy;
  logic      [SHAMT_W:0][WIDTH-1:0]   data_s;
  logic      [SHAMT_W:0][SHAMT_W-1:0] shamt_s;
  shift_op_t [SHAMT_W:0]              op_s;
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  logic      [SHAMT_W:0]              carry_s;
  assign carry_s[0] = 1'b0;
`endif

  assign vld_pipe[0]  = in_valid;
  assign data_s[0]    = in_data;
  assign shamt_s[0]   = in_shamt;
  assign op_s[0]      = in_op;
  assign rdy[SHAMT_W] = out_ready;

  for (genvar k = 0; k < SHAMT_W; k++) begin : g_stage
    shift_stage #(.WIDTH(WIDTH), .SHAMT_W(SHAMT_W), .K(k)) u_stage (
      .clk        (clk),
      .reset      (reset),
      .prev_valid (vld_pipe[k]),
      .ready      (rdy[k]),
      .prev_data  (data_s[k]),
      .prev_shamt (shamt_s[k]),
      .prev_op    (op_s[k]),
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
      .prev_carry (carry_s[k]),
      .carry      (carry_s[k+1]),
`endif
      .next_ready (rdy[k+1]),
      .valid      (vld_pipe[k+1]),
      .data       (data_s[k+1]),
      .shamt      (shamt_s[k+1]),
      .op         (op_s[k+1])
    );
  end

  // The tail stage's shamt/op have no consumer.
  logic unused_tail;
  assign unused_tail = ^{shamt_s[SHAMT_W], op_s[SHAMT_W]};

  assign in_ready  = rdy[0];
  assign out_valid = vld_pipe[SHAMT_W];
  assign out_data  = data_s[SHAMT_W];
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  assign out_carry = carry_s[SHAMT_W];
  // Qualified by valid so an empty (or just reset) pipe reports zero=0.
  assign out_zero  = out_valid && (out_data == '0);
`endif
endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed bench for barrel_shift_pipe (WIDTH=16): vector table plus handshake corner sequences.
module tb_barrel_shift_pipe;
  import shift_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic [3:0]  in_shamt = '0;
  shift_op_t   in_op = SH_LSL;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
  logic        out_carry;
  logic        out_zero;
`endif

  barrel_shift_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
    ,
    .out_carry (out_carry),
    .out_zero  (out_zero)
`endif
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Independent whole-amount reference: {carry, data}.
  function automatic logic [16:0] model(input shift_op_t op, input logic [15:0] d, input logic [3:0] sh);
    int s;
    logic [15:0] r;
    logic signed [15:0] sd;
    logic c;
    s  = int'(sh);
    sd = d;
    r  = d;
    c  = 1'b0;
    case (op)
      SH_LSL: begin r = d << s;   if (s != 0) c = d[16-s]; end
      SH_LSR: begin r = d >> s;   if (s != 0) c = d[s-1]; end
      SH_ASR: begin r = sd >>> s; if (s != 0) c = d[s-1]; end
      default: begin r = (d >> s) | (d << (16 - s)); if (s != 0) c = r[15]; end
    endcase
    return {c, r};
  endfunction

  task automatic push(input shift_op_t op, input logic [15:0] d, input logic [3:0] sh);
    in_valid = 1'b1;
    in_op    = op;
    in_data  = d;
    in_shamt = sh;
  endtask

  typedef struct {
    shift_op_t   op;
    logic [15:0] d;
    logic [3:0]  sh;
    logic [15:0] exp;
    logic        c;
  } vec_t;

  vec_t vecs[12];

  shift_op_t   b_op[8];
  logic [15:0] b_d[8];
  logic [3:0]  b_sh[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cyc, n, stale;
    logic found;
    logic [16:0] m;

    vecs[0]  = '{SH_LSL, 16'h00F0, 4'd4,  16'h0F00, 1'b0};
    vecs[1]  = '{SH_ASR, 16'h8001, 4'd1,  16'hC000, 1'b1};
    vecs[2]  = '{SH_LSR, 16'h8000, 4'd15, 16'h0001, 1'b0};
    vecs[3]  = '{SH_ROR, 16'h1234, 4'd4,  16'h4123, 1'b0};
    vecs[4]  = '{SH_ROR, 16'h1234, 4'd0,  16'h1234, 1'b0};
    vecs[5]  = '{SH_LSL, 16'h0001, 4'd15, 16'h8000, 1'b0};
    vecs[6]  = '{SH_LSL, 16'h0001, 4'd1,  16'h0002, 1'b0};
    vecs[7]  = '{SH_ASR, 16'hF000, 4'd4,  16'hFF00, 1'b0};
    vecs[8]  = '{SH_ASR, 16'h7FF0, 4'd15, 16'h0000, 1'b1};
    vecs[9]  = '{SH_LSR, 16'h00FF, 4'd4,  16'h000F, 1'b1};
    vecs[10] = '{SH_LSL, 16'hC000, 4'd2,  16'h0000, 1'b1};
    vecs[11] = '{SH_ROR, 16'h0001, 4'd1,  16'h8000, 1'b1};

    b_op = '{SH_LSL, SH_LSR, SH_ASR, SH_ROR, SH_ROR, SH_ASR, SH_LSR, SH_LSL};
    b_d  = '{16'hA5A5, 16'hF00F, 16'h8421, 16'hBEEF, 16'h0F0F, 16'h7FFF, 16'hFFFF, 16'h1357};
    b_sh = '{4'd3, 4'd7, 4'd9, 4'd13, 4'd8, 4'd2, 4'd0, 4'd11};

    // Reset state, including an op offered while reset is held.
    @(negedge clk);
    push(SH_LSL, 16'hFFFF, 4'd1);
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(out_valid), 0);
    chk("reset_out_data", 32'(out_data), 0);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("reset_in_ready", 32'(in_ready), 1);
    repeat (6) @(negedge clk);
    chk("reset_drop_in_valid", 32'(out_valid), 0);

    // Single-op table: result, latency and flags.
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      push(vecs[i].op, vecs[i].d, vecs[i].sh);
      cyc = 0;
      found = 1'b0;
      while (!found && cyc < 12) begin
        @(negedge clk);
        in_valid = 1'b0;
        cyc++;
        if (out_valid) found = 1'b1;
      end
      chk($sformatf("vec%0d_latency", i), 32'(cyc), 4);
      chk($sformatf("vec%0d_data", i), 32'(out_data), 32'(vecs[i].exp));
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
      chk($sformatf("vec%0d_carry", i), 32'(out_carry), 32'(vecs[i].c));
      chk($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].exp == 16'h0));
`endif
    end

    // Eight back-to-back ops, results on consecutive cycles from cycle 4.
    @(negedge clk);
    n = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push(b_op[i], b_d[i], b_sh[i]);
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int c = 1; c <= 20; c++) begin
          @(negedge clk);
          if (out_valid) begin
            if (n < 8) begin
              m = model(b_op[n], b_d[n], b_sh[n]);
              chk($sformatf("b2b%0d_data", n), 32'(out_data), 32'(m[15:0]));
              chk($sformatf("b2b%0d_cycle", n), 32'(c), 32'(4 + n));
`ifdef BARREL_SHIFT_PIPE_FLAGS_EN
              chk($sformatf("b2b%0d_carry", n), 32'(out_carry), 32'(m[16]));
`endif
            end
            n++;
          end
        end
      end
    join
    chk("b2b_count", 32'(n), 8);

    // Fill under backpressure, stall 3 cycles, then drain.
    @(negedge clk);
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push(b_op[i], b_d[i], b_sh[i]);
      @(negedge clk);
    end
    in_valid = 1'b0;
    m = model(b_op[0], b_d[0], b_sh[0]);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("stall%0d_in_ready", i), 32'(in_ready), 0);
      chk($sformatf("stall%0d_out_valid", i), 32'(out_valid), 1);
      chk($sformatf("stall%0d_out_data", i), 32'(out_data), 32'(m[15:0]));
      @(negedge clk);
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        if (n < 4) begin
          m = model(b_op[n], b_d[n], b_sh[n]);
          chk($sformatf("drain%0d_data", n), 32'(out_data), 32'(m[15:0]));
        end
        n++;
      end
      @(negedge clk);
    end
    chk("drain_count", 32'(n), 4);

    // Reset with three ops in flight and one offered during reset.
    for (int i = 0; i < 3; i++) begin
      push(b_op[i + 4], b_d[i + 4], b_sh[i + 4]);
      @(negedge clk);
    end
    reset = 1'b1;
    push(SH_ROR, 16'hCAFE, 4'd5);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_out_data", 32'(out_data), 0);
    chk("flush_in_ready", 32'(in_ready), 1);
    stale = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("flush_no_stale", 32'(stale), 0);

    // Pipe still works after the flush.
    push(SH_LSR, 16'h8000, 4'd15);
    cyc = 0;
    found = 1'b0;
    while (!found && cyc < 12) begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      if (out_valid) found = 1'b1;
    end
    chk("post_flush_latency", 32'(cyc), 4);
    chk("post_flush_data", 32'(out_data), 32'h0001);

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
